vpe_weights_mem: RTL and testbench

VPE_WEIGHTS_MEM -- requirements
Module: vpe_weights_mem

---
 rtl/vpe_pkg.sv | 15 +
 rtl/vpe_wmem_bank.sv | 43 ++++
 rtl/vpe_weights_mem.sv | 113 +++++++++++
 tb/tb_vpe_weights_mem.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vpe_pkg.sv
// rtl/vpe_pkg.sv - shared defaults for the VPE weight memory
// Holds the default bank geometry and the bank image file prefix, plus a
// helper that sizes bank-select fields (at least one bit wide).
package vpe_pkg;

    localparam int    VPE_NUM_BANKS    = 4;
    localparam int    VPE_BANK_W       = 512;
    localparam int    VPE_WDEPTH       = 256;
    localparam string VPE_WBANK_PREFIX = "wbank_";

    function automatic int bsel_width(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/vpe_wmem_bank.sv
// rtl/vpe_wmem_bank.sv - single-port weight bank with registered read
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset (read register only)
//   en     - access enable for this cycle
//   we     - write when high with en, otherwise read
//   addr   - word address
//   wdata  - write word
//   rdata  - registered read word, held between reads
// The storage array has no reset; only the read register is cleared.
module vpe_wmem_bank
    import vpe_pkg::*;
#(
    parameter  int BANK_W = VPE_BANK_W,
    parameter  int DEPTH  = VPE_WDEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BANK_W-1:0] wdata,
    output logic [BANK_W-1:0] rdata
);

    logic [BANK_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/vpe_weights_mem.sv
// rtl/vpe_weights_mem.sv - banked weight memory with read/load arbitration
// Ports:
//   clk, rst        - rising-edge clock, asynchronous active-low reset
//   rd_valid/ready  - read request handshake, raddr common to all banks
//   o_data          - all banks concatenated, bank 0 in the top slice
//   o_data_valid    - one-cycle pulse qualifying o_data
//   ld_valid/ready  - runtime load handshake (ld_bank, ld_addr, ld_data)
//   ld_err          - sticky: a load addressed a nonexistent bank
// Build option VPE_WMEM_OUTREG_EN adds an output register (latency 2
// instead of 1).
module vpe_weights_mem
    import vpe_pkg::*;
#(
    parameter  int NUM_BANKS = VPE_NUM_BANKS,
    parameter  int BANK_W    = VPE_BANK_W,
    parameter  int DEPTH     = VPE_WDEPTH,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int BSEL_W    = bsel_width(NUM_BANKS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rd_valid,
    output logic                        rd_ready,
    input  logic [ADDR_W-1:0]           raddr,
    output logic [NUM_BANKS*BANK_W-1:0] o_data,
    output logic                        o_data_valid,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [BSEL_W-1:0]           ld_bank,
    input  logic [ADDR_W-1:0]           ld_addr,
    input  logic [BANK_W-1:0]           ld_data,
    output logic                        ld_err
);

    // High when the load refused last cycle gets the next tie.
    logic prio_ld;
    logic rd_fire;
    logic ld_fire;
    logic bank_ok;
    logic rd_vld_q;
    logic [ADDR_W-1:0]           mem_addr;
    logic [NUM_BANKS*BANK_W-1:0] rd_word;

    // Each ready looks only at the competing valid, so a lone requester is
    // always granted and the two grants can never coincide.
    assign rd_ready = rst && !(ld_valid && prio_ld);
    assign ld_ready = rst && !(rd_valid && !prio_ld);
    assign rd_fire  = rd_valid && rd_ready;
    assign ld_fire  = ld_valid && ld_ready;
    assign bank_ok  = 32'(ld_bank) < NUM_BANKS;
    assign mem_addr = ld_fire ? ld_addr : raddr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_ld  <= 1'b0;
            ld_err   <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            prio_ld  <= ld_valid && !ld_ready;
            rd_vld_q <= rd_fire;
            if (ld_fire && !bank_ok) begin
                ld_err <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic              wr;
        logic [BANK_W-1:0] bank_q;

        assign wr = ld_fire && bank_ok && (ld_bank == BSEL_W'(i));

        vpe_wmem_bank #(
            .BANK_W (BANK_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (rd_fire || wr),
            .we    (wr),
            .addr  (mem_addr),
            .wdata (ld_data),
            .rdata (bank_q)
        );

        assign rd_word[(NUM_BANKS-1-i)*BANK_W +: BANK_W] = bank_q;
    end

`ifdef VPE_WMEM_OUTREG_EN
    logic [NUM_BANKS*BANK_W-1:0] out_q;
    logic                        out_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            out_vld <= 1'b0;
        end else begin
            out_vld <= rd_vld_q;
            if (rd_vld_q) begin
                out_q <= rd_word;
            end
        end
    end

    assign o_data       = out_q;
    assign o_data_valid = out_vld;
`else
    // Bank read registers only update on reads, so o_data holds by itself.
    assign o_data       = rd_word;
    assign o_data_valid = rd_vld_q;
`endif

endmodule

// File: tb/tb_vpe_weights_mem.sv
// tb/tb_vpe_weights_mem.sv - self-checking bench for vpe_weights_mem
module tb_vpe_weights_mem;

    localparam int NB = 4;
    localparam int BW = 32;
    localparam int DP = 16;
    localparam int AW = 4;
`ifdef VPE_WMEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          rd_valid = 1'b0;
    logic          ld_valid = 1'b0;
    logic [AW-1:0] raddr    = '0;
    logic [AW-1:0] ld_addr  = '0;
    logic [1:0]    ld_bank  = '0;
    logic [BW-1:0] ld_data  = '0;

    logic             rd_ready, ld_ready, o_data_valid, ld_err;
    logic [NB*BW-1:0] o_data;
    logic             rd_ready3, ld_ready3, o_data_valid3, ld_err3;
    logic [3*BW-1:0]  o_data3;

    vpe_weights_mem #(.NUM_BANKS(NB), .BANK_W(BW), .DEPTH(DP)) u_dut (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .raddr(raddr),
        .o_data(o_data), .o_data_valid(o_data_valid),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_bank(ld_bank),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err)
    );

    vpe_weights_mem #(.NUM_BANKS(3), .BANK_W(BW), .DEPTH(DP)) u_dut3 (
        .clk(clk), .rst(rst),
        .rd_valid(rd_valid), .rd_ready(rd_ready3), .raddr(raddr),
        .o_data(o_data3), .o_data_valid(o_data_valid3),
        .ld_valid(ld_valid), .ld_ready(ld_ready3), .ld_bank(ld_bank),
        .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] iw(input int b, input int a);
        return {8'(8'hB0 + b), 8'(a), 16'hCAFE};
    endfunction

    // Cycle index: increments on every rising edge.
    int pcnt = 0;
    always @(posedge clk) pcnt++;

    // Reference model: word store, delay line of expected reads, arbitration
    // rule (a load refused last cycle wins the next tie).
    logic [BW-1:0]    mm [NB][DP];
    logic             pv [LAT+1];
    logic [NB*BW-1:0] pd [LAT+1];
    logic [NB*BW-1:0] held;
    logic             m_lfirst;
    logic             m_err;
    logic [NB*BW-1:0] seen_d [$];
    int               seen_c [$];

    always @(negedge clk) begin : cmp
        logic er, el, rf, lf;
        if (!rst) begin
            chk("rst_rd_ready", rd_ready, 0);
            chk("rst_ld_ready", ld_ready, 0);
            chk("rst_o_data_valid", o_data_valid, 0);
            chk("rst_o_data", o_data, 0);
            chk("rst_ld_err", ld_err, 0);
            m_lfirst = 1'b0;
            m_err    = 1'b0;
            held     = '0;
            for (int k = 1; k <= LAT; k++) pv[k] = 1'b0;
        end else begin
            er = !(ld_valid && m_lfirst);
            el = !(rd_valid && !m_lfirst);
            chk("rd_ready", rd_ready, er);
            chk("ld_ready", ld_ready, el);
            chk("o_data_valid", o_data_valid, pv[LAT]);
            if (pv[LAT]) held = pd[LAT];
            chk("o_data", o_data, held);
            chk("ld_err", ld_err, m_err);
            if (o_data_valid) begin
                seen_d.push_back(o_data);
                seen_c.push_back(pcnt);
            end
            rf = rd_valid && er;
            lf = ld_valid && el;
            for (int k = LAT; k > 1; k--) begin
                pv[k] = pv[k-1];
                pd[k] = pd[k-1];
            end
            pv[1] = rf;
            pd[1] = {mm[0][raddr], mm[1][raddr], mm[2][raddr], mm[3][raddr]};
            if (lf) begin
                if (int'(ld_bank) < NB) mm[ld_bank][ld_addr] = ld_data;
                else m_err = 1'b1;
            end
            m_lfirst = ld_valid && !el;
        end
    end

    logic g_rd, g_ld, g_ld3;
    int   fire_c;

    // Drive one cycle of inputs (called just after a rising edge) and record
    // the grants seen at the following falling edge.
    task automatic cyc(input logic rv, input int ra, input logic lv, input int lb,
                       input int la, input logic [BW-1:0] d);
        rd_valid = rv;
        raddr    = AW'(ra);
        ld_valid = lv;
        ld_bank  = 2'(lb);
        ld_addr  = AW'(la);
        ld_data  = d;
        @(negedge clk);
        g_rd   = rd_valid && rd_ready;
        g_ld   = ld_valid && ld_ready;
        g_ld3  = ld_valid && ld_ready3;
        fire_c = pcnt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, '0);
    endtask

    task automatic flush();
        seen_d.delete();
        seen_c.delete();
    endtask

    logic [127:0] b2b [4] = '{
        128'hB000CAFE_B100CAFE_B200CAFE_B300CAFE,
        128'hB001CAFE_B101CAFE_B201CAFE_B301CAFE,
        128'hB002CAFE_B102CAFE_B202CAFE_B302CAFE,
        128'hB003CAFE_B103CAFE_B203CAFE_B303CAFE
    };

    initial begin
        int       f0;
        logic [5:0] pat;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("err3_after_reset", ld_err3, 0);

        // Fill every word through the load port.
        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DP; a++)
                cyc(0, 0, 1, b, a, iw(b, a));
        chk("err3_after_bank3_loads", ld_err3, 1);

        // Word 5 of bank i = (i+1) repeated.
        for (int i = 0; i < NB; i++) cyc(0, 0, 1, i, 5, 32'h11111111 * (i + 1));
        flush();
        cyc(1, 5, 0, 0, 0, '0);
        chk("rd5_grant", g_rd, 1);
        f0 = fire_c;
        idle(4);
        chk("rd5_count", seen_d.size(), 1);
        if (seen_d.size() > 0) begin
            chk("rd5_latency", seen_c[0] - f0, LAT);
            chk("rd5_data", seen_d[0], 128'h11111111_22222222_33333333_44444444);
        end

        // Back-to-back reads of addresses 0..3.
        flush();
        for (int a = 0; a < 4; a++) begin
            cyc(1, a, 0, 0, 0, '0);
            if (a == 0) f0 = fire_c;
        end
        idle(5);
        chk("b2b_count", seen_d.size(), 4);
        for (int k = 0; k < 4 && k < seen_d.size(); k++) begin
            chk("b2b_cycle", seen_c[k] - f0, LAT + k);
            chk("b2b_data", seen_d[k], b2b[k]);
        end

        // Both requesters held: grants alternate starting with the read.
        for (int k = 0; k < 6; k++) begin
            cyc(1, 4, 1, 1, 4, 32'h0BADF00D);
            pat[k] = g_ld;
            chk("arb_one_grant", g_rd ^ g_ld, 1);
        end
        chk("arb_pattern", pat, 6'b101010);
        idle(4);

        // Load then read the same address on the next cycle.
        cyc(0, 0, 1, 2, 7, 32'hA5A5A5A5);
        flush();
        cyc(1, 7, 0, 0, 0, '0);
        idle(4);
        chk("rdaw_count", seen_d.size(), 1);
        if (seen_d.size() > 0)
            chk("rdaw_data", seen_d[0], 128'hB007CAFE_B107CAFE_A5A5A5A5_B307CAFE);

        // Reset with reads in flight.
        cyc(1, 0, 0, 0, 0, '0);
        cyc(1, 1, 0, 0, 0, '0);
        rd_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("rst_now_valid", o_data_valid, 0);
        chk("rst_now_data", o_data, 0);
        chk("rst_now_rd_ready", rd_ready, 0);
        chk("rst_now_ld_ready", ld_ready, 0);
        chk("rst_now_err3", ld_err3, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        flush();
        idle(6);
        chk("no_stale_valid", seen_d.size(), 0);
        chk("post_rst_data", o_data, 0);

        // Three-bank instance: bank 3 does not exist.
        chk("err3_clear", ld_err3, 0);
        cyc(0, 0, 1, 3, 9, 32'hDEADBEEF);
        chk("bad_bank_ld_ready", g_ld3, 1);
        chk("bad_bank_err_set", ld_err3, 1);
        flush();
        cyc(1, 9, 0, 0, 0, '0);
        idle(4);
        chk("bad_bank_err_sticky", ld_err3, 1);
        chk("bad_bank_unchanged", o_data3, 96'hB009CAFE_B109CAFE_B209CAFE);
        chk("bank3_count", seen_d.size(), 1);
        if (seen_d.size() > 0)
            chk("bank3_data", seen_d[0], 128'hB009CAFE_B109CAFE_B209CAFE_DEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
